// File: rtl/uart_core_if.sv
// ============================================================================
// Module   : uart_core_if
// Purpose  : Pin, configuration and valid/ready bundle for uart_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_core_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic                 uart_rxd;
  logic                 uart_txd;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [1:0]           cfg_parity;
  logic                 cfg_stop2;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output uart_rxd, cfg_div, cfg_parity, cfg_stop2, tx_data, tx_valid, rx_ready,
    input  uart_txd, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  uart_rxd, cfg_div, cfg_parity, cfg_stop2, tx_data, tx_valid, rx_ready,
    output uart_txd, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_core.sv
// ============================================================================
// Module   : uart_core
// Purpose  : UART transceiver, runtime divisor, parity/stop options, 3-sample
//            majority RX. Optional macro UART_LOOPBACK_EN adds a loopback port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_core #(
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input wire logic   clk,
  input wire logic   rst,
`ifdef UART_LOOPBACK_EN
  input wire logic   loopback,
`endif
  uart_core_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0]     c_last_idx = BIT_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] c_one      = DIV_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               r_tx_state, w_tx_state_nxt;
  logic [DIV_WIDTH-1:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
  logic [BIT_W-1:0]     r_tx_idx, w_tx_idx_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic r_tx_par_en, w_tx_par_en_nxt, r_tx_par_bit, w_tx_par_bit_nxt;
  logic r_tx_stop2, w_tx_stop2_nxt, r_tx_second, w_tx_second_nxt;
  logic r_tx_bit, w_tx_bit_nxt, r_tx_ready, w_tx_ready_nxt;

  always_comb begin
    w_tx_state_nxt = r_tx_state;   w_tx_cnt_nxt     = r_tx_cnt;
    w_tx_div_nxt   = r_tx_div;     w_tx_idx_nxt     = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;   w_tx_par_en_nxt  = r_tx_par_en;
    w_tx_par_bit_nxt = r_tx_par_bit; w_tx_stop2_nxt = r_tx_stop2;
    w_tx_second_nxt = r_tx_second; w_tx_bit_nxt     = r_tx_bit;
    w_tx_ready_nxt = r_tx_ready;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_bit_nxt   = 1'b1;
        w_tx_ready_nxt = 1'b1;
        if (bus.tx_valid && r_tx_ready) begin
          w_tx_state_nxt   = S_START;
          w_tx_div_nxt     = bus.cfg_div;
          w_tx_cnt_nxt     = bus.cfg_div - c_one;
          w_tx_shift_nxt   = bus.tx_data;
          w_tx_par_en_nxt  = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
          w_tx_par_bit_nxt = (^bus.tx_data) ^ bus.cfg_parity[1];
          w_tx_stop2_nxt   = bus.cfg_stop2;
          w_tx_bit_nxt     = 1'b0;
          w_tx_ready_nxt   = 1'b0;
        end
      end
      default: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - c_one;
        end else begin
          w_tx_cnt_nxt = r_tx_div - c_one;
          case (r_tx_state)
            S_START: begin
              w_tx_state_nxt = S_DATA;
              w_tx_idx_nxt   = '0;
              w_tx_bit_nxt   = r_tx_shift[0];
            end
            S_DATA: begin
              if (r_tx_idx == c_last_idx) begin
                w_tx_state_nxt  = r_tx_par_en ? S_PARITY : S_STOP;
                w_tx_bit_nxt    = r_tx_par_en ? r_tx_par_bit : 1'b1;
                w_tx_second_nxt = 1'b0;
              end else begin
                w_tx_idx_nxt   = r_tx_idx + 1'b1;
                w_tx_shift_nxt = r_tx_shift >> 1;
                w_tx_bit_nxt   = r_tx_shift[1];
              end
            end
            S_PARITY: begin
              w_tx_state_nxt  = S_STOP;
              w_tx_bit_nxt    = 1'b1;
              w_tx_second_nxt = 1'b0;
            end
            S_STOP: begin
              if (r_tx_stop2 && !r_tx_second) begin
                w_tx_second_nxt = 1'b1;
              end else begin
                w_tx_state_nxt = S_IDLE;
                w_tx_ready_nxt = 1'b1;
              end
            end
            default: w_tx_state_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= S_IDLE; r_tx_cnt <= '0; r_tx_div <= '0; r_tx_idx <= '0;
      r_tx_shift <= '0; r_tx_par_en <= 1'b0; r_tx_par_bit <= 1'b0;
      r_tx_stop2 <= 1'b0; r_tx_second <= 1'b0; r_tx_bit <= 1'b1; r_tx_ready <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt; r_tx_cnt <= w_tx_cnt_nxt; r_tx_div <= w_tx_div_nxt;
      r_tx_idx <= w_tx_idx_nxt; r_tx_shift <= w_tx_shift_nxt; r_tx_par_en <= w_tx_par_en_nxt;
      r_tx_par_bit <= w_tx_par_bit_nxt; r_tx_stop2 <= w_tx_stop2_nxt;
      r_tx_second <= w_tx_second_nxt; r_tx_bit <= w_tx_bit_nxt; r_tx_ready <= w_tx_ready_nxt;
    end
  end

  assign bus.tx_ready = r_tx_ready;

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '1;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.uart_rxd};
  end

`ifdef UART_LOOPBACK_EN
  assign w_rxs        = loopback ? r_tx_bit : r_sync[SYNC_STAGES-1];
  assign bus.uart_txd = r_tx_bit | loopback;
`else
  assign w_rxs        = r_sync[SYNC_STAGES-1];
  assign bus.uart_txd = r_tx_bit;
`endif

  state_t               r_rx_state, w_rx_state_nxt;
  logic [DIV_WIDTH-1:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
  logic [DIV_WIDTH-1:0] w_rx_off, w_rx_half;
  logic [BIT_W-1:0]     r_rx_idx, w_rx_idx_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [1:0]           r_rx_votes, w_rx_votes_nxt;
  logic r_rx_par_en, w_rx_par_en_nxt, r_rx_par_odd, w_rx_par_odd_nxt;
  logic r_rx_par_bad, w_rx_par_bad_nxt, r_rx_armed, w_rx_armed_nxt;
  logic w_s_lo, w_s_mid, w_s_hi, w_rx_maj, w_rx_last, w_rx_done;

  // Offset within the current bit, counted from the reload of the down-counter
  assign w_rx_off  = r_rx_div - c_one - r_rx_cnt;
  assign w_rx_half = r_rx_div >> 1;
  assign w_s_lo    = (w_rx_off == w_rx_half - c_one);
  assign w_s_mid   = (w_rx_off == w_rx_half);
  assign w_s_hi    = (w_rx_off == w_rx_half + c_one);
  assign w_rx_maj  = (r_rx_votes + {1'b0, w_rxs}) >= 2'd2;
  assign w_rx_last = (r_rx_cnt == '0);

  always_comb begin
    w_rx_state_nxt = r_rx_state;   w_rx_cnt_nxt     = r_rx_cnt;
    w_rx_div_nxt   = r_rx_div;     w_rx_idx_nxt     = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;   w_rx_votes_nxt   = r_rx_votes;
    w_rx_par_en_nxt = r_rx_par_en; w_rx_par_odd_nxt = r_rx_par_odd;
    w_rx_par_bad_nxt = r_rx_par_bad; w_rx_armed_nxt = r_rx_armed;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rxs) w_rx_armed_nxt = 1'b1;
        if (r_rx_armed && !w_rxs) begin
          w_rx_state_nxt   = S_START;
          w_rx_div_nxt     = bus.cfg_div;
          w_rx_cnt_nxt     = bus.cfg_div - c_one;
          w_rx_par_en_nxt  = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
          w_rx_par_odd_nxt = bus.cfg_parity[1];
          w_rx_par_bad_nxt = 1'b0;
        end
      end
      default: begin
        w_rx_cnt_nxt = w_rx_last ? (r_rx_div - c_one) : (r_rx_cnt - c_one);
        if (w_s_lo)  w_rx_votes_nxt = {1'b0, w_rxs};
        if (w_s_mid) w_rx_votes_nxt = r_rx_votes + {1'b0, w_rxs};
        case (r_rx_state)
          S_START: begin
            if (w_s_hi && w_rx_maj) begin
              w_rx_state_nxt = S_IDLE;
            end else if (w_rx_last) begin
              w_rx_state_nxt = S_DATA;
              w_rx_idx_nxt   = '0;
            end
          end
          S_DATA: begin
            if (w_s_hi) w_rx_shift_nxt = {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
            if (w_rx_last) begin
              if (r_rx_idx == c_last_idx) w_rx_state_nxt = r_rx_par_en ? S_PARITY : S_STOP;
              else                        w_rx_idx_nxt   = r_rx_idx + 1'b1;
            end
          end
          S_PARITY: begin
            if (w_s_hi)    w_rx_par_bad_nxt = w_rx_maj ^ (^r_rx_shift) ^ r_rx_par_odd;
            if (w_rx_last) w_rx_state_nxt   = S_STOP;
          end
          S_STOP: begin
            // Leave mid-bit; a low stop (break) disarms until the line idles high
            if (w_s_hi) begin
              w_rx_done      = 1'b1;
              w_rx_state_nxt = S_IDLE;
              w_rx_armed_nxt = w_rx_maj;
            end
          end
          default: w_rx_state_nxt = S_IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= S_IDLE; r_rx_cnt <= '0; r_rx_div <= '0; r_rx_idx <= '0;
      r_rx_shift <= '0; r_rx_votes <= '0; r_rx_par_en <= 1'b0; r_rx_par_odd <= 1'b0;
      r_rx_par_bad <= 1'b0; r_rx_armed <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt; r_rx_cnt <= w_rx_cnt_nxt; r_rx_div <= w_rx_div_nxt;
      r_rx_idx <= w_rx_idx_nxt; r_rx_shift <= w_rx_shift_nxt; r_rx_votes <= w_rx_votes_nxt;
      r_rx_par_en <= w_rx_par_en_nxt; r_rx_par_odd <= w_rx_par_odd_nxt;
      r_rx_par_bad <= w_rx_par_bad_nxt; r_rx_armed <= w_rx_armed_nxt;
    end
  end

  logic [DATA_BITS-1:0] r_rx_data;
  logic r_rx_valid, r_rx_fe, r_rx_pe, r_rx_ovr, w_rx_hs;

  assign w_rx_hs = r_rx_valid && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_data <= '0; r_rx_valid <= 1'b0; r_rx_fe <= 1'b0; r_rx_pe <= 1'b0; r_rx_ovr <= 1'b0;
    end else if (w_rx_done) begin
      r_rx_data  <= r_rx_shift;
      r_rx_fe    <= !w_rx_maj;
      r_rx_pe    <= r_rx_par_bad;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !bus.rx_ready) r_rx_ovr <= 1'b1;
      else if (w_rx_hs)                r_rx_ovr <= 1'b0;
    end else if (w_rx_hs) begin
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_frame_err  = r_rx_fe;
  assign bus.rx_parity_err = r_rx_pe;
  assign bus.rx_overrun    = r_rx_ovr;

endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
// ============================================================================
// Module   : tb_uart_core
// Purpose  : Self-checking bench for uart_core against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_core;
  localparam int DATA_BITS = 8;
  localparam int DIV_WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_core_if #(.DATA_BITS(DATA_BITS), .DIV_WIDTH(DIV_WIDTH)) bus ();

  uart_core #(.DATA_BITS(DATA_BITS), .DIV_WIDTH(DIV_WIDTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic even_bit(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Transmit one word and compare the line against the ideal bit sequence
  task automatic tx_frame(input logic [7:0] d, input int div, input logic [1:0] par, input logic s2);
    logic exp_bits[$];
    logic seen;
    int   budget;
    int   ready_bad;
    budget = 0;
    while (bus.tx_ready !== 1'b1 && budget < 1000) begin
      tick();
      budget++;
    end
    check("tx_ready_before", 32'(bus.tx_ready), 32'd1);
    bus.tx_data = d; bus.cfg_div = 16'(div); bus.cfg_parity = par; bus.cfg_stop2 = s2;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'($urandom);
    bus.cfg_div    = 16'($urandom_range(8, 30));
    bus.cfg_parity = 2'($urandom_range(0, 3));
    bus.cfg_stop2  = 1'($urandom_range(0, 1));
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par == 2'b01) exp_bits.push_back(even_bit(d));
    if (par == 2'b10) exp_bits.push_back(!even_bit(d));
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
    ready_bad = 0;
    foreach (exp_bits[b]) begin
      seen = exp_bits[b];
      for (int c = 0; c < div; c++) begin
        if (bus.uart_txd !== exp_bits[b]) seen = bus.uart_txd;
        if (bus.tx_ready !== 1'b0) ready_bad++;
        tick();
      end
      check($sformatf("tx_d%02h_bit%0d", d, b), 32'(seen), 32'(exp_bits[b]));
    end
    check("tx_ready_high_in_frame", ready_bad, 0);
    check("tx_ready_after", 32'(bus.tx_ready), 32'd1);
  endtask

  task automatic rx_drive(input logic v, input int n);
    bus.uart_rxd = v;
    tick(n);
  endtask

  // Serialise a frame onto the line; spike_bit<8 inverts one cycle mid-bit
  task automatic rx_frame(input logic [7:0] d, input int div, input logic [1:0] par,
                          input logic pbit, input logic stop, input int spike_bit);
    bus.cfg_div = 16'(div); bus.cfg_parity = par;
    rx_drive(1'b0, div);
    bus.cfg_div = 16'($urandom_range(8, 30));
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        rx_drive(d[i], div / 2);
        rx_drive(!d[i], 1);
        rx_drive(d[i], div - div / 2 - 1);
      end else begin
        rx_drive(d[i], div);
      end
    end
    if (par == 2'b01 || par == 2'b10) rx_drive(pbit, div);
    rx_drive(stop, div);
    rx_drive(1'b1, div + 4);
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] d, input logic fe,
                           input logic pe, input logic ovr);
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rx_data), 32'(d));
    check({tag, "_fe"},    32'(bus.rx_frame_err), 32'(fe));
    check({tag, "_pe"},    32'(bus.rx_parity_err), 32'(pe));
    check({tag, "_ovr"},   32'(bus.rx_overrun), 32'(ovr));
  endtask

  task automatic rx_ack(input string tag);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_ovr_clr"},   32'(bus.rx_overrun), 32'd0);
  endtask

  function automatic logic model_pe(input logic [7:0] d, input logic [1:0] par, input logic pbit);
    if (par == 2'b01) return pbit != even_bit(d);
    if (par == 2'b10) return pbit != !even_bit(d);
    return 1'b0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] par;
    logic       pbit, stop;
    int         div, cnt;
    logic       fe_seen;

    bus.uart_rxd = 1'b1; bus.cfg_div = 16'd16; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    rst = 1'b0;
    tick(3);
    check("rst_txd",      32'(bus.uart_txd), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data",  32'(bus.rx_data), 32'd0);
    check("rst_fe",       32'(bus.rx_frame_err), 32'd0);
    check("rst_pe",       32'(bus.rx_parity_err), 32'd0);
    check("rst_ovr",      32'(bus.rx_overrun), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Directed transmit, then randomised transmits
    tx_frame(8'hA5, 16, 2'b00, 1'b0);
    for (int k = 0; k < 6; k++)
      tx_frame(8'($urandom), $urandom_range(8, 24), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Reset during data bit 3 abandons the frame
    bus.tx_data = 8'hFF; bus.cfg_div = 16'd16; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    tick(4 * 16 + 5);
    rst = 1'b0;
    tick();
    check("midrst_txd",      32'(bus.uart_txd), 32'd1);
    check("midrst_tx_ready", 32'(bus.tx_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_ready_after", 32'(bus.tx_ready), 32'd1);
    tx_frame(8'h5A, 16, 2'b00, 1'b0);

    // Directed receive with even and odd parity
    rx_frame(8'h3C, 16, 2'b01, 1'b0, 1'b1, 99);
    rx_expect("rx3c_even", 8'h3C, 1'b0, model_pe(8'h3C, 2'b01, 1'b0), 1'b0);
    rx_ack("rx3c_even");
    rx_frame(8'h3C, 16, 2'b10, 1'b0, 1'b1, 99);
    rx_expect("rx3c_odd", 8'h3C, 1'b0, model_pe(8'h3C, 2'b10, 1'b0), 1'b0);
    rx_ack("rx3c_odd");

    // Short low glitch is a false start
    rx_drive(1'b0, 3);
    rx_drive(1'b1, 4 * 16);
    check("glitch_no_valid", 32'(bus.rx_valid), 32'd0);

    // Mid-bit spike rejected by the majority vote
    rx_frame(8'hB6, 16, 2'b00, 1'b0, 1'b1, 2);
    rx_expect("spike", 8'hB6, 1'b0, 1'b0, 1'b0);
    rx_ack("spike");

    // Break: exactly one framing-error frame, none after release
    bus.rx_ready = 1'b1; bus.cfg_div = 16'd16; bus.cfg_parity = 2'b00;
    cnt = 0; fe_seen = 1'b0;
    bus.uart_rxd = 1'b0;
    for (int c = 0; c < 160 + 200; c++) begin
      if (bus.rx_valid === 1'b1) begin
        cnt++;
        fe_seen = bus.rx_frame_err;
      end
      tick();
    end
    check("break_frames", cnt, 1);
    check("break_fe", 32'(fe_seen), 32'd1);
    cnt = 0;
    bus.uart_rxd = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (bus.rx_valid === 1'b1) cnt++;
      tick();
    end
    check("break_release_frames", cnt, 0);
    bus.rx_ready = 1'b0;

    // Overrun: second frame overwrites unread first
    rx_frame(8'h11, 16, 2'b00, 1'b0, 1'b1, 99);
    rx_frame(8'h22, 16, 2'b00, 1'b0, 1'b1, 99);
    rx_expect("overrun", 8'h22, 1'b0, 1'b0, 1'b1);
    rx_ack("overrun");

    // Randomised receive frames
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      div  = $urandom_range(8, 24);
      par  = 2'($urandom_range(0, 3));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      rx_frame(d, div, par, pbit, stop, $urandom_range(0, 11));
      rx_expect($sformatf("rxr%0d", k), d, !stop, model_pe(d, par, pbit), 1'b0);
      rx_ack($sformatf("rxr%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
